rv_mem_arb: RTL and testbench

RV_MEM_ARB -- requirements
Module: rv_mem_arb

---
 rtl/rv_mem_arb.sv | 121 ++++++++++++
 tb/tb_rv_mem_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// Two-port (instruction fetch / data) arbiter onto a single synchronous memory port.
// Define RV_MEM_ARB_RR_EN to make the IDLE tie-break round-robin instead of fixed data priority.
module rv_mem_arb #(
  parameter int DPWIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [DPWIDTH-1:0] i_addr,
  output logic               i_ack,
  output logic [DPWIDTH-1:0] i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DPWIDTH-1:0] d_addr,
  input  logic [DPWIDTH-1:0] d_wdata,
  output logic               d_ack,
  output logic [DPWIDTH-1:0] d_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DPWIDTH-1:0] mem_addr,
  output logic [DPWIDTH-1:0] mem_wdata,
  input  logic [DPWIDTH-1:0] mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  owner_t             tie_sel, grant_sel;
  logic               grant;
  logic               mem_en_d, mem_we_d;
  logic [DPWIDTH-1:0] mem_addr_d, mem_wdata_d;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    grant       = 1'b0;
    grant_sel   = owner_q;
`ifdef RV_MEM_ARB_RR_EN
    // The owner register doubles as "last served": the other port wins a tie.
    tie_sel = (owner_q == OWN_D) ? OWN_I : OWN_D;
`else
    tie_sel = OWN_D;
`endif

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          grant     = 1'b1;
          grant_sel = tie_sel;
        end else if (d_req) begin
          grant     = 1'b1;
          grant_sel = OWN_D;
        end else if (i_req) begin
          grant     = 1'b1;
          grant_sel = OWN_I;
        end
      end
      ACC: state_d = RESP;
      RESP: begin
        // Only the non-owner may be handed the memory straight from RESP.
        state_d = IDLE;
        if (owner_q == OWN_I && d_req) begin
          grant     = 1'b1;
          grant_sel = OWN_D;
        end else if (owner_q == OWN_D && i_req) begin
          grant     = 1'b1;
          grant_sel = OWN_I;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d  = ACC;
      owner_d  = grant_sel;
      mem_en_d = 1'b1;
      if (grant_sel == OWN_D) begin
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
        mem_we_d    = d_we;
      end else begin
        mem_addr_d = i_addr;
        mem_we_d   = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_D;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign i_ack   = (state_q == RESP) && (owner_q == OWN_I);
  assign d_ack   = (state_q == RESP) && (owner_q == OWN_D);
  assign i_rdata = i_ack ? mem_rdata : '0;
  assign d_rdata = d_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench for rv_mem_arb: directed vector table, corner-case sequences and a
// randomized run against a cycle-slot transaction model.
module tb_rv_mem_arb;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_we;
  logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic         i_ack, d_ack, mem_en, mem_we, busy;
  logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  rv_mem_arb #(.DPWIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef RV_MEM_ARB_RR_EN
  localparam bit FIRST_TIE_D = 1'b0;
`else
  localparam bit FIRST_TIE_D = 1'b1;
`endif

  typedef struct {
    logic         i_req;
    logic [W-1:0] i_addr;
    logic         d_req;
    logic         d_we;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] rdata;
    logic         exp_d;
    logic [W-1:0] exp_addr;
    logic         exp_we;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One transaction from IDLE: request in cycle 0, ACC in cycle 1, ack in cycle 2.
  task automatic run_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    check($sformatf("v%0d_c0_mem_en", idx), mem_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d_acc_mem_en", idx), mem_en, 1);
    check($sformatf("v%0d_acc_addr", idx), mem_addr, v.exp_addr);
    check($sformatf("v%0d_acc_we", idx), mem_we, v.exp_we);
    if (v.exp_we) check($sformatf("v%0d_acc_wdata", idx), mem_wdata, v.d_wdata);
    @(posedge clk); #1;
    mem_rdata = v.rdata;
    @(negedge clk);
    check($sformatf("v%0d_resp_i_ack", idx), i_ack, !v.exp_d);
    check($sformatf("v%0d_resp_d_ack", idx), d_ack, v.exp_d);
    check($sformatf("v%0d_resp_mem_en", idx), mem_en, 0);
    if (v.exp_d && !v.exp_we) check($sformatf("v%0d_d_rdata", idx), d_rdata, v.rdata);
    if (!v.exp_d) check($sformatf("v%0d_i_rdata", idx), i_rdata, v.rdata);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check($sformatf("v%0d_after_busy", idx), busy, 0);
  endtask

  // Random phase state
  int           resp_c;
  logic         m_own_d, e_we, e_chk_wdata;
  logic [W-1:0] e_addr, e_wdata;
  logic         saw_i, saw_d;

  initial begin
    drive_idle();
    rst = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_55AA, 32'h1111_2222, 1'b1, 32'h0000_0200, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0304, 32'hAAAA_AAAA, 32'h1234_5678, 1'b1, 32'h0000_0304, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0};

    reset_dut();
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Both ports held continuously: alternating grants, one ack every 2 cycles.
    reset_dut();
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h0000_1000; d_req = 1; d_we = 0; d_addr = 32'h0000_2000;
    mem_rdata = 32'hCAFE_0000;
    for (int k = 0; k < 10; k++) begin
      bit own_d;
      int n;
      @(negedge clk);
      check($sformatf("alt_k%0d_mem_en", k), mem_en, k % 2);
      if (k % 2 == 1) begin
        n = (k - 1) / 2;
        own_d = FIRST_TIE_D ^ n[0];
        check($sformatf("alt_k%0d_addr", k), mem_addr, own_d ? 32'h0000_2000 : 32'h0000_1000);
      end
      if (k >= 2 && k % 2 == 0) begin
        n = k / 2 - 1;
        own_d = FIRST_TIE_D ^ n[0];
        check($sformatf("alt_k%0d_i_ack", k), i_ack, !own_d);
        check($sformatf("alt_k%0d_d_ack", k), d_ack, own_d);
      end else begin
        check($sformatf("alt_k%0d_no_ack", k), {i_ack, d_ack}, 0);
      end
      @(posedge clk); #1;
    end
    drive_idle();

    // Reset asserted during ACC abandons the access; a re-issued request completes.
    reset_dut();
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h0000_0040;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstacc_in_acc", mem_en, 1);
    rst = 1'b0;
    #1;
    check("rstacc_mem_en", mem_en, 0);
    check("rstacc_busy", busy, 0);
    check("rstacc_acks", {i_ack, d_ack}, 0);
    check("rstacc_addr", mem_addr, 0);
    @(posedge clk); #1;
    check("rstacc_hold_ack", d_ack, 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int found_at;
      found_at = -1;
      for (int k = 0; k < 8 && found_at < 0; k++) begin
        @(negedge clk);
        if (d_ack) found_at = k;
      end
      check("rstacc_reissue_latency", found_at, 1);
    end
    @(posedge clk); #1;
    drive_idle();

    // Request dropped during ACC still completes with an ack.
    reset_dut();
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h0000_0080;
    @(negedge clk);
    @(posedge clk); #1;
    i_req = 0;
    @(negedge clk);
    check("drop_acc_mem_en", mem_en, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_i_ack", i_ack, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_idle_busy", busy, 0);
    check("drop_idle_ack", i_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_idle_mem_en", mem_en, 0);

    // Randomized run against a slot model: a grant decided in cycle c puts ACC in c+1 and the ack in c+2.
    reset_dut();
    resp_c = -10;
    m_own_d = 1'b1;
    e_we = 0; e_addr = '0; e_wdata = '0; e_chk_wdata = 0;
    saw_i = 0; saw_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit exp_en, exp_ia, exp_da, win_d, do_grant;
      @(posedge clk); #1;
      if (saw_i) i_req = 0;
      if (saw_d) d_req = 0;
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_rdata = $urandom;
      @(negedge clk);
      exp_en = (cyc == resp_c - 1);
      exp_ia = (cyc == resp_c) && !m_own_d;
      exp_da = (cyc == resp_c) && m_own_d;
      check("rnd_mem_en", mem_en, exp_en);
      check("rnd_i_ack", i_ack, exp_ia);
      check("rnd_d_ack", d_ack, exp_da);
      if (exp_en) begin
        check("rnd_addr", mem_addr, e_addr);
        check("rnd_we", mem_we, e_we);
        if (e_chk_wdata) check("rnd_wdata", mem_wdata, e_wdata);
      end
      if (exp_ia) check("rnd_i_rdata", i_rdata, mem_rdata);
      if (exp_da && !e_we) check("rnd_d_rdata", d_rdata, mem_rdata);
      saw_i = exp_ia;
      saw_d = exp_da;

      do_grant = 0;
      win_d = 0;
      if (cyc > resp_c) begin
        if (i_req && d_req) begin
          do_grant = 1;
`ifdef RV_MEM_ARB_RR_EN
          win_d = !m_own_d;
`else
          win_d = 1;
`endif
        end else if (i_req || d_req) begin
          do_grant = 1;
          win_d = d_req;
        end
      end else if (cyc == resp_c) begin
        if (m_own_d && i_req) begin
          do_grant = 1; win_d = 0;
        end else if (!m_own_d && d_req) begin
          do_grant = 1; win_d = 1;
        end
      end
      if (do_grant) begin
        resp_c = cyc + 2;
        m_own_d = win_d;
        e_addr = win_d ? d_addr : i_addr;
        e_we = win_d ? d_we : 1'b0;
        e_wdata = d_wdata;
        e_chk_wdata = win_d && d_we;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
